// File: rtl/barrier_release_ctrl.sv
// Barrier release controller: gathers per-producer end-of-epoch markers,
// then opens the gated queue for exactly the summed frame count.
module barrier_release_ctrl #(
  parameter int NUM_SRC     = 4,
  parameter int CNT_WIDTH   = 8,
  parameter int EPOCH_WIDTH = 8,
  parameter int SUM_WIDTH   = CNT_WIDTH + $clog2(NUM_SRC + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SRC-1:0]             s_done_valid,
  output logic [NUM_SRC-1:0]             s_done_ready,
  input  logic [NUM_SRC*CNT_WIDTH-1:0]   s_done_count,
  input  logic                           mon_tvalid,
  input  logic                           mon_tready,
  input  logic                           mon_tlast,
  output logic                           barrier,
  output logic [EPOCH_WIDTH-1:0]         epoch,
  output logic                           busy,
  output logic                           err_unexpected
);

  typedef enum logic {
    COLLECT = 1'b0,
    OPEN    = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  logic [NUM_SRC-1:0]     got;
  logic [NUM_SRC-1:0]     acc;
  logic [SUM_WIDTH-1:0]   expected;
  logic [SUM_WIDTH-1:0]   remaining;
  logic [SUM_WIDTH-1:0]   add_sum;
  logic [SUM_WIDTH-1:0]   total;
  logic                   all_in;
  logic                   fire;
  logic                   last_fire;

  assign fire      = mon_tvalid & mon_tready & mon_tlast;
  assign last_fire = fire && (remaining == SUM_WIDTH'(1));
  assign acc       = s_done_valid & s_done_ready;
  assign all_in    = &(got | acc);
  assign total     = expected + add_sum;

  always_comb begin
    add_sum = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (acc[i]) begin
        add_sum = add_sum
          + SUM_WIDTH'(s_done_count[i*CNT_WIDTH +: CNT_WIDTH]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      COLLECT: if (all_in && total != '0) next_state = OPEN;
      OPEN:    if (last_fire)             next_state = COLLECT;
      default: next_state = COLLECT;
    endcase
  end

  // Outputs decode only the state flop, so mon_* never reach them.
  always_comb begin
    barrier      = (state == OPEN);
    busy         = (state == OPEN);
    s_done_ready = (state == COLLECT) ? ~got : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      got            <= '0;
      expected       <= '0;
      remaining      <= '0;
      epoch          <= '0;
      err_unexpected <= 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (fire) err_unexpected <= 1'b1;
          if (all_in && total == '0) begin
            got      <= '0;
            expected <= '0;
            epoch    <= epoch + EPOCH_WIDTH'(1);
          end else if (all_in) begin
            got       <= got | acc;
            expected  <= total;
            remaining <= total;
          end else begin
            got      <= got | acc;
            expected <= total;
          end
        end
        OPEN: begin
          if (fire) remaining <= remaining - SUM_WIDTH'(1);
          if (last_fire) begin
            got      <= '0;
            expected <= '0;
            epoch    <= epoch + EPOCH_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_barrier_release_ctrl.sv
// Randomized bench for barrier_release_ctrl against an
// epoch/frame-count reference model.
module tb_barrier_release_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  s_done_valid = '0;
  logic [3:0]  s_done_ready;
  logic [31:0] s_done_count = '0;
  logic        mon_tvalid = 1'b0;
  logic        mon_tready = 1'b0;
  logic        mon_tlast = 1'b0;
  logic        barrier;
  logic [7:0]  epoch;
  logic        busy;
  logic        err_unexpected;

  int checks = 0;
  int failures = 0;

  bit m_open;
  bit m_got[4];
  int m_exp;
  int m_rem;
  int m_epoch;
  bit m_err;

  barrier_release_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_done_valid(s_done_valid),
    .s_done_ready(s_done_ready),
    .s_done_count(s_done_count),
    .mon_tvalid(mon_tvalid),
    .mon_tready(mon_tready),
    .mon_tlast(mon_tlast),
    .barrier(barrier),
    .epoch(epoch),
    .busy(busy),
    .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_open = 0;
    m_exp = 0;
    m_rem = 0;
    m_epoch = 0;
    m_err = 0;
    foreach (m_got[i]) m_got[i] = 0;
  endtask

  task automatic check_outputs();
    logic [3:0] rdy;
    for (int i = 0; i < 4; i++) rdy[i] = !m_open && !m_got[i];
    chk("barrier", 32'(barrier), 32'(m_open));
    chk("busy", 32'(busy), 32'(m_open));
    chk("ready", 32'(s_done_ready), 32'(rdy));
    chk("epoch", 32'(epoch), 32'(m_epoch));
    chk("err", 32'(err_unexpected), 32'(m_err));
  endtask

  // Called on a falling edge: check, drive, advance model, wait.
  task automatic step(input logic [3:0] v, input logic [31:0] cnts,
                      input logic tv, input logic tr, input logic tl);
    bit fire;
    bit all;
    int sum;
    check_outputs();
    s_done_valid = v;
    s_done_count = cnts;
    mon_tvalid = tv;
    mon_tready = tr;
    mon_tlast = tl;
    fire = tv && tr && tl;
    if (!m_open) begin
      if (fire) m_err = 1;
      sum = m_exp;
      all = 1;
      for (int i = 0; i < 4; i++) begin
        if (v[i] && !m_got[i]) begin
          m_got[i] = 1;
          sum += int'(cnts[i*8 +: 8]);
        end
        all = all && m_got[i];
      end
      m_exp = sum;
      if (all) begin
        if (sum != 0) begin
          m_open = 1;
          m_rem = sum;
        end else begin
          m_epoch = (m_epoch + 1) % 256;
          m_exp = 0;
          foreach (m_got[i]) m_got[i] = 0;
        end
      end
    end else if (fire) begin
      m_rem--;
      if (m_rem == 0) begin
        m_open = 0;
        m_exp = 0;
        m_epoch = (m_epoch + 1) % 256;
        foreach (m_got[i]) m_got[i] = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int e0;
    logic [31:0] c;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(s_done_ready), 32'hf);
    chk("rst_barrier", 32'(barrier), 32'h0);
    idle(1);

    // Separate-cycle markers {2,0,1,3}, then 6 frames of 3 beats.
    c = {8'd3, 8'd1, 8'd0, 8'd2};
    step(4'b0001, c, 0, 0, 0);
    step(4'b0010, c, 0, 0, 0);
    step(4'b0100, c, 0, 0, 0);
    step(4'b1000, c, 0, 0, 0);
    chk("open_barrier", 32'(barrier), 32'h1);
    for (int f = 0; f < 6; f++)
      for (int b = 0; b < 3; b++) step(4'h0, 32'h0, 1, 1, b == 2);
    chk("closed_barrier", 32'(barrier), 32'h0);
    chk("epoch1", 32'(epoch), 32'h1);
    idle(2);

    // All four markers in one cycle, stalled consumer.
    step(4'hf, {8'd1, 8'd1, 8'd1, 8'd1}, 0, 0, 0);
    repeat (60) begin
      if (m_open)
        step(4'h0, 32'h0, 1, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      else
        idle(1);
    end

    // Zero-count epoch.
    step(4'hf, 32'h0, 0, 0, 0);
    idle(2);

    // Fire in COLLECT after a partial accept.
    step(4'b0001, 32'd5, 0, 0, 0);
    step(4'h0, 32'h0, 1, 1, 1);
    idle(2);
    chk("err_sticky", 32'(err_unexpected), 32'h1);
    step(4'b1110, {8'd0, 8'd0, 8'd0, 8'd0}, 0, 0, 0);
    repeat (5) step(4'h0, 32'h0, 1, 1, 1);
    idle(1);

    // Reset mid-OPEN with three frames outstanding.
    step(4'hf, {8'd0, 8'd0, 8'd1, 8'd2}, 0, 0, 0);
    chk("pre_rst_barrier", 32'(barrier), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("async_barrier", 32'(barrier), 32'h0);
    chk("async_epoch", 32'(epoch), 32'h0);
    model_reset();
    s_done_valid = '0;
    mon_tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Epoch wrap over 256 zero-count epochs.
    e0 = m_epoch;
    repeat (256) step(4'hf, 32'h0, 0, 0, 0);
    chk("wrap", 32'(epoch), 32'(e0));

    // Random traffic.
    repeat (3000) begin
      logic [31:0] rc;
      logic tv;
      for (int i = 0; i < 4; i++) rc[i*8 +: 8] = 8'($urandom_range(0, 3));
      tv = m_open ? 1'($urandom_range(0, 1))
                  : ($urandom_range(0, 63) == 0);
      step(4'($urandom), rc, tv, 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) == 0);
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
